spi_sck_ctrl: RTL and testbench



---
 rtl/spi_sck_ctrl.sv | 93 +++++++++
 tb/tb_spi_sck_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_sck_ctrl.sv
// spi_sck_ctrl: SPI SCK divider/sequencer with mode-aligned shift and sample strobes
module spi_sck_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
  output logic             sck,
  output logic             shift_stb,
  output logic             sample_stb,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [DIV_W-1:0] r_div, r_hcnt;
  logic [CNT_W-1:0] r_nbits;
  logic [CNT_W:0]   r_edge;
  logic             r_cpol, r_cpha, r_sck, r_shift, r_sample, r_busy, r_done;
  logic             w_tog, w_last, w_lead;
  logic [CNT_W:0]   w_edge;
  assign w_tog  = r_hcnt == r_div;
  assign w_edge = r_edge + 1'b1;
  assign w_last = w_edge == {r_nbits, 1'b0};
  assign w_lead = w_edge[0];
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_hcnt   <= '0;
      r_nbits  <= '0;
      r_edge   <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_sck    <= 1'b0;
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= (r_state == RUN) && !abort;
      case (r_state)
        IDLE: begin
          r_sck <= cpol;
          if (start && !abort) begin
            if (nbits != '0) begin
              r_div   <= div;
              r_nbits <= nbits;
              r_cpol  <= cpol;
              r_cpha  <= cpha;
              r_hcnt  <= '0;
              r_edge  <= '0;
              r_state <= RUN;
            end else r_state <= DONE;
          end
        end
        RUN: begin
          if (abort) begin
            r_sck   <= r_cpol;
            r_state <= IDLE;
          end else if (w_tog) begin
            // odd edge numbers are leading edges; the final trailing edge never shifts
            r_hcnt   <= '0;
            r_edge   <= w_edge;
            r_sck    <= ~r_sck;
            r_sample <= r_cpha ? !w_lead : w_lead;
            r_shift  <= r_cpha ? w_lead : (!w_lead && !w_last);
            if (w_last) r_state <= DONE;
          end else r_hcnt <= r_hcnt + 1'b1;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign sck        = r_sck;
  assign shift_stb  = r_shift;
  assign sample_stb = r_sample;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_spi_sck_ctrl.sv
// tb_spi_sck_ctrl: directed vector bench for spi_sck_ctrl
module tb_spi_sck_ctrl;
  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] div = '0;
  logic [5:0] nbits = '0;
  logic       sck, shift_stb, sample_stb, busy, done;
  int         n_chk = 0, n_pass = 0;

  typedef struct {
    logic [7:0] div;
    logic [5:0] nbits;
    logic       cpol, cpha;
    int         first, tog, samp, shf, dcyc, bcnt;
  } vec_t;
  vec_t vecs[5];

  spi_sck_ctrl #(.DIV_W(8), .CNT_W(6)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort), .div(div),
    .nbits(nbits), .cpol(cpol), .cpha(cpha), .sck(sck), .shift_stb(shift_stb),
    .sample_stb(sample_stb), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // start a transfer, scramble the settings inputs and retry start mid-transfer,
  // then tally every observable event per cycle relative to the start edge
  task automatic run_vec(input vec_t v);
    int first = 0, tog = 0, samp = 0, shf = 0, dcyc = 0, dn = 0, bcnt = 0, bfirst = 0, bad = 0, fsck = -1;
    logic psck, tg, lead;
    div = v.div; nbits = v.nbits; cpol = v.cpol; cpha = v.cpha; start = 1'b1;
    step();
    start = 1'b0; div = ~v.div; nbits = v.nbits + 6'd7; cpha = ~v.cpha;
    psck = sck;
    for (int k = 1; k <= v.dcyc + 3; k++) begin
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      step();
      tg = sck !== psck;
      lead = sck !== v.cpol;
      if (tg) begin tog++; if (first == 0) first = k; end
      if (sample_stb) begin samp++; if (!tg || lead !== !v.cpha) bad++; end
      if (shift_stb) begin shf++; if (!tg || lead !== v.cpha) bad++; end
      if (shift_stb && sample_stb) bad++;
      if (busy) begin bcnt++; if (bfirst == 0) bfirst = k; end
      if (done) begin dn++; dcyc = k; fsck = int'(sck); end
      psck = sck;
    end
    cpha = v.cpha;
    chk("first_toggle", first, v.first);
    chk("toggles", tog, v.tog);
    chk("sample_cnt", samp, v.samp);
    chk("shift_cnt", shf, v.shf);
    chk("strobe_align", bad, 0);
    chk("done_cycle", dcyc, v.dcyc);
    chk("done_pulses", dn, 1);
    chk("busy_cycles", bcnt, v.bcnt);
    chk("busy_first", bfirst, 1);
    chk("final_sck", fsck, int'(v.cpol));
  endtask

  initial begin
    int tog, dn, bc;
    logic psck;
    vecs[0] = '{8'd1, 6'd8, 1'b0, 1'b0, 2, 16, 8, 7, 33, 32};
    vecs[1] = '{8'd0, 6'd4, 1'b1, 1'b1, 1, 8, 4, 4, 9, 8};
    vecs[2] = '{8'd2, 6'd3, 1'b0, 1'b1, 3, 6, 3, 3, 19, 18};
    vecs[3] = '{8'd0, 6'd1, 1'b1, 1'b0, 1, 2, 1, 0, 3, 2};
    vecs[4] = '{8'd4, 6'd2, 1'b1, 1'b0, 5, 4, 2, 1, 21, 20};

    #3;
    chk("reset_outputs", int'({sck, shift_stb, sample_stb, busy, done}), 0);
    #20 rst = 1'b1;
    step();
    step();
    chk("idle_sck", int'(sck), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // abort after the 5th toggle
    div = 8'd3; nbits = 6'd8; cpol = 1'b1; cpha = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    psck = sck; tog = 0;
    for (int k = 0; k < 100 && tog < 5; k++) begin
      step();
      if (sck !== psck) tog++;
      psck = sck;
    end
    chk("abort_reach", tog, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outputs", int'({busy, sck, shift_stb, sample_stb}), 4);
    dn = 0; bc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) dn++;
      if (busy) bc++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_busy", bc, 0);

    // abort and start together in IDLE: start dropped
    div = 8'd0; nbits = 6'd4; abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    psck = sck; tog = 0; dn = 0; bc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (sck !== psck) tog++;
      if (done) dn++;
      if (busy) bc++;
      psck = sck;
    end
    chk("abort_start_activity", tog + dn + bc, 0);
    run_vec(vecs[1]);

    // nbits=0 no-op
    div = 8'd2; nbits = 6'd0; cpol = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    psck = sck; tog = 0; dn = 0; bc = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (sck !== psck) tog++;
      if (done) begin dn++; chk("noop_done_cycle", k, 1); end
      if (busy) bc++;
      psck = sck;
    end
    chk("noop_done_pulses", dn, 1);
    chk("noop_busy", bc, 0);
    chk("noop_toggles", tog, 0);

    // asynchronous reset mid-transfer
    div = 8'd2; nbits = 6'd16; cpol = 1'b1; cpha = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("pre_reset_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outputs", int'({sck, shift_stb, sample_stb, busy, done}), 0);
    #2 rst = 1'b1;
    step();
    step();
    chk("post_reset_idle", int'({sck, busy, done}), 4);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
